mips_dcache_ctrl: RTL and testbench
===================================

Name: mips_dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller placed directly downstream of the pipelined MIPS MEM stage.
- Consumes the MEM stage's word request (MemRead/MemWrite, data_address_2DM, data_write_2DM) and returns the read word.
- Drives the 256-bit block interface to data memory (dBlkRead/dBlkWrite, block_write_2DM, block_read_fDM).
- Stalls the pipeline through FREEZE while a miss is serviced.

Parameters:
- LINES, 32, number of cache lines; power of two. Index width IW = log2(LINES).
- TAGW, 27-IW, tag width. 32-bit address = {tag, index, word[2:0], byte[1:0]}.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MemRead  in  1  word load request from MEM stage.
- MemWrite  in  1  word store request from MEM stage.
- data_address_2DM  in  32  byte address of the request; bits [1:0] ignored.
- data_write_2DM  in  32  store data.
- data_read_fDM  out  32  load data to MEM stage.
- FREEZE  out  1  pipeline stall.
- dBlkRead  out  1  block refill request to data memory.
- dBlkWrite  out  1  block writeback request to data memory.
- blk_address  out  32  block address, with bits [4:0] = 0.
- block_write_2DM  out  256  victim line for writeback.
- block_read_fDM  in  256  refill line from memory.
- blk_ready  in  1  memory has completed the current block request; single-cycle pulse.

Behaviour:
- Storage: per line a valid bit, a dirty bit, a TAGW tag and 8 data words. Word w occupies bits [32w+31:32w] of the line and the block buses.
- Reset (RESET=0, asynchronous):
  - all valid and dirty bits cleared; state is IDLE.
  - data_read_fDM=0, FREEZE=0, dBlkRead=0, dBlkWrite=0, blk_address=0, block_write_2DM=0.
  - Data and tag arrays are not cleared.
  - Reset mid-miss aborts the transfer. Dirty data is discarded; this is accepted.
- A request is active when MemRead|MemWrite. If both are set, MemWrite takes priority.
- Hit = active & valid[idx] & tag[idx]==addr tag.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE, hit:
  - Read hit: data_read_fDM = addressed word, combinationally in the same cycle. FREEZE=0.
  - Write hit: the addressed word is written at the clock edge and dirty[idx] is set. FREEZE=0.
- IDLE, miss:
  - FREEZE=1 combinationally in the same cycle.
  - The request address is latched into miss_addr at the edge.
  - Next state is WRITEBACK if valid[idx]&dirty[idx], otherwise REFILL.
- No request: data_read_fDM holds its last value and FREEZE=0.
- WRITEBACK:
  - FREEZE=1, dBlkWrite=1.
  - blk_address = {victim tag, idx, 5'b0}; block_write_2DM = victim line.
  - Outputs are held stable until blk_ready, then go to REFILL.
- REFILL:
  - FREEZE=1, dBlkRead=1, blk_address = {miss_addr[31:5], 5'b0}.
  - On blk_ready: install block_read_fDM and set valid=1, dirty=0, tag = miss tag. Go to IDLE.
- dBlkRead and dBlkWrite are never both 1. Both deassert in the cycle after blk_ready.
- After REFILL the pipeline still presents the same request, so it hits in IDLE. A store merges into the line at that point.
- FREEZE drops in the first IDLE cycle after the refill completes.
- Miss latency:
  - Clean miss: 1 (detect) + refill cycles up to and including blk_ready + 1 (hit) cycles.
  - Dirty miss: additionally adds the writeback cycles.
- Stability: the requester holds its request stable while FREEZE=1. The controller uses miss_addr, not the live address, during WRITEBACK and REFILL.
- blk_ready in IDLE is ignored.
- Index/tag wrap: addresses that differ only in the tag map to the same line and evict each other.

Test Plan:
- Reset then a read at 0x0000_0040, memory answering with blk_ready after 3 cycles and line word0=0xDEADBEEF -> FREEZE=1 for 5 cycles, dBlkRead with blk_address=0x40, then data_read_fDM=0xDEADBEEF and FREEZE=0.
- Read hit at 0x44 after the previous fill -> data_read_fDM = word1 in the same cycle, FREEZE never asserted, dBlkRead stays 0.
- Write 0x12345678 to 0x48, then read 0x48 -> hit both times, read returns 0x12345678, no block traffic.
- Read 0x0000_1048, which with LINES=32 maps to the same index as 0x48 -> dBlkWrite first with blk_address=0x40 and block_write_2DM word2=0x12345678, then dBlkRead at 0x1040, then hit.
- Assert RESET during REFILL -> outputs zero asynchronously; after release, a read of 0x40 misses again (valid cleared).
- MemRead=MemWrite=1 to a cached address -> treated as a store: word updated and dirty set.

Source files
------------

// File: rtl/mips_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MIPS MEM stage and
// a 256-bit block memory; stalls the pipeline with FREEZE while a miss is serviced.
module mips_dcache_ctrl #(
    parameter int LINES = 32,
    parameter int TAGW  = 27 - $clog2(LINES)
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         MemRead,
    input  logic         MemWrite,
    input  logic [31:0]  data_address_2DM,
    input  logic [31:0]  data_write_2DM,
    output logic [31:0]  data_read_fDM,
    output logic         FREEZE,
    output logic         dBlkRead,
    output logic         dBlkWrite,
    output logic [31:0]  blk_address,
    output logic [255:0] block_write_2DM,
    input  logic [255:0] block_read_fDM,
    input  logic         blk_ready
);
    localparam int IW = $clog2(LINES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAGW-1:0]   tag_q  [LINES];
    logic [255:0]      data_q [LINES];
    logic [26:0]       miss_addr_q;
    logic [31:0]       rdata_q;

    logic              req_s;
    logic              hit_s;
    logic [IW-1:0]     idx_s;
    logic [IW-1:0]     midx_s;
    logic [TAGW-1:0]   tag_s;
    logic [TAGW-1:0]   mtag_s;
    logic [2:0]        word_s;
    logic [7:0]        boff_s;
    logic [31:0]       word_rd_s;
    logic [1:0]        byte_unused_s;

    logic              freeze_s;
    logic              rd_hit_s;
    logic              wr_hit_s;
    logic              latch_s;
    logic              fill_s;
    logic              blk_rd_s;
    logic              blk_wr_s;
    logic [31:0]       blk_addr_s;
    logic [255:0]      blk_wdata_s;

    assign req_s         = MemRead | MemWrite;
    assign idx_s         = data_address_2DM[5 +: IW];
    assign tag_s         = data_address_2DM[31 -: TAGW];
    assign word_s        = data_address_2DM[4:2];
    assign boff_s        = {word_s, 5'd0};
    assign byte_unused_s = data_address_2DM[1:0];
    assign midx_s        = miss_addr_q[IW-1:0];
    assign mtag_s        = miss_addr_q[26 -: TAGW];
    assign word_rd_s     = data_q[idx_s][boff_s +: 32];
    assign hit_s         = req_s & valid_q[idx_s] & (tag_q[idx_s] == tag_s);

    // Next-state and block-interface decode; during a miss only miss_addr_q is consulted
    always_comb begin
        state_d     = state_q;
        freeze_s    = 1'b0;
        rd_hit_s    = 1'b0;
        wr_hit_s    = 1'b0;
        latch_s     = 1'b0;
        fill_s      = 1'b0;
        blk_rd_s    = 1'b0;
        blk_wr_s    = 1'b0;
        blk_addr_s  = 32'd0;
        blk_wdata_s = 256'd0;
        case (state_q)
            IDLE: begin
                if (hit_s) begin
                    wr_hit_s = MemWrite;
                    rd_hit_s = ~MemWrite;
                end else if (req_s) begin
                    freeze_s = 1'b1;
                    latch_s  = 1'b1;
                    state_d  = (valid_q[idx_s] & dirty_q[idx_s]) ? WRITEBACK : REFILL;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                freeze_s    = 1'b1;
                blk_wr_s    = 1'b1;
                blk_addr_s  = {tag_q[midx_s], midx_s, 5'd0};
                blk_wdata_s = data_q[midx_s];
                state_d     = blk_ready ? REFILL : WRITEBACK;
            end
            REFILL: begin
                freeze_s   = 1'b1;
                blk_rd_s   = 1'b1;
                blk_addr_s = {miss_addr_q, 5'd0};
                fill_s     = blk_ready;
                state_d    = blk_ready ? IDLE : REFILL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FREEZE is forced low while reset is held even though a request may still be presented
    assign FREEZE          = freeze_s & RESET;
    assign dBlkRead        = blk_rd_s;
    assign dBlkWrite       = blk_wr_s;
    assign blk_address     = blk_addr_s;
    assign block_write_2DM = blk_wdata_s;
    assign data_read_fDM   = rd_hit_s ? word_rd_s : rdata_q;

    // Control state: FSM, per-line valid/dirty, latched miss address and held load data
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_addr_q <= 27'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            if (fill_s) begin
                valid_q[midx_s] <= 1'b1;
                dirty_q[midx_s] <= 1'b0;
            end else if (wr_hit_s) begin
                dirty_q[idx_s] <= 1'b1;
            end
            if (latch_s) begin
                miss_addr_q <= data_address_2DM[31:5];
            end
            if (rd_hit_s) begin
                rdata_q <= word_rd_s;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify their contents
    always_ff @(posedge CLK) begin
        if (fill_s) begin
            data_q[midx_s] <= block_read_fDM;
            tag_q[midx_s]  <= mtag_s;
        end else if (wr_hit_s) begin
            data_q[idx_s][boff_s +: 32] <= data_write_2DM;
        end
    end
endmodule

// File: tb/tb_mips_dcache_ctrl.sv
// Bench for mips_dcache_ctrl: a line-level cache/memory model predicts every cycle's
// outputs, and directed scenarios add hand-computed literal expectations.
module tb_mips_dcache_ctrl;
    localparam int LINES = 32;
    localparam int IW    = 5;
    localparam int TAGW  = 22;
    localparam int DELAY = 3;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         MemRead = 1'b0;
    logic         MemWrite = 1'b0;
    logic [31:0]  data_address_2DM = 32'd0;
    logic [31:0]  data_write_2DM = 32'd0;
    logic [255:0] block_read_fDM = 256'd0;
    logic         blk_ready = 1'b0;
    logic [31:0]  data_read_fDM;
    logic         FREEZE;
    logic         dBlkRead;
    logic         dBlkWrite;
    logic [31:0]  blk_address;
    logic [255:0] block_write_2DM;

    always #5 CLK = ~CLK;

    mips_dcache_ctrl #(.LINES(LINES)) dut (
        .CLK(CLK), .RESET(RESET), .MemRead(MemRead), .MemWrite(MemWrite),
        .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
        .data_read_fDM(data_read_fDM), .FREEZE(FREEZE), .dBlkRead(dBlkRead),
        .dBlkWrite(dBlkWrite), .blk_address(blk_address), .block_write_2DM(block_write_2DM),
        .block_read_fDM(block_read_fDM), .blk_ready(blk_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } xfer_t;

    xfer_t          xq[$];
    xfer_t          x_m;
    bit             m_valid [LINES];
    bit             m_dirty [LINES];
    logic [TAGW-1:0] m_tag  [LINES];
    logic [255:0]   m_data  [LINES];
    logic [31:0]    m_last = 32'd0;
    logic [255:0]   mem [logic [31:0]];
    logic [31:0]    a_m;
    int             i_m;

    function automatic logic [255:0] mem_rd(input logic [31:0] a);
        logic [255:0] r;
        if (mem.exists(a)) return mem[a];
        for (int w = 0; w < 8; w++) r[32*w +: 32] = (a + 32'(4 * w)) ^ 32'h5A5A0000;
        return r;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'(a[5 +: IW]);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == a[31 -: TAGW]);
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        return m_data[m_idx(a)][32 * int'(a[4:2]) +: 32];
    endfunction

    // Model advance at each edge: transfers complete on blk_ready, hits read/write the line
    always @(posedge CLK) begin
        if (!RESET) begin
            foreach (m_valid[k]) begin
                m_valid[k] = 1'b0;
                m_dirty[k] = 1'b0;
            end
            xq.delete();
            m_last = 32'd0;
        end else if (xq.size() != 0) begin
            if (blk_ready) begin
                x_m = xq.pop_front();
                i_m = m_idx(x_m.addr);
                if (x_m.wr) begin
                    mem[x_m.addr] = x_m.data;
                end else begin
                    m_data[i_m]  = mem_rd(x_m.addr);
                    m_valid[i_m] = 1'b1;
                    m_dirty[i_m] = 1'b0;
                    m_tag[i_m]   = x_m.addr[31 -: TAGW];
                end
            end
        end else if (MemRead || MemWrite) begin
            a_m = data_address_2DM;
            i_m = m_idx(a_m);
            if (m_hit(a_m)) begin
                if (MemWrite) begin
                    m_data[i_m][32 * int'(a_m[4:2]) +: 32] = data_write_2DM;
                    m_dirty[i_m] = 1'b1;
                end else begin
                    m_last = m_word(a_m);
                end
            end else begin
                if (m_valid[i_m] && m_dirty[i_m])
                    xq.push_back('{wr: 1'b1, addr: {m_tag[i_m], a_m[5 +: IW], 5'd0}, data: m_data[i_m]});
                xq.push_back('{wr: 1'b0, addr: {a_m[31:5], 5'd0}, data: 256'd0});
            end
        end
    end

    // ---------------- per-cycle compare + observation ----------------
    bit          s_rd = 1'b0, s_wr = 1'b0;
    logic [31:0] s_addr = 32'd0;
    int          n_blk = 0;
    bit          rd_seen = 1'b0, wb_seen = 1'b0;
    logic [31:0] rd_cap = 32'd0, wb_cap_addr = 32'd0;
    logic [255:0] wb_cap_data = 256'd0;

    always @(negedge CLK) begin
        s_rd   = dBlkRead;
        s_wr   = dBlkWrite;
        s_addr = blk_address;
        if (dBlkRead || dBlkWrite) n_blk++;
        if (dBlkRead && !rd_seen) begin
            rd_seen = 1'b1;
            rd_cap  = blk_address;
        end
        if (dBlkWrite && !wb_seen) begin
            wb_seen     = 1'b1;
            wb_cap_addr = blk_address;
            wb_cap_data = block_write_2DM;
        end
        if (!RESET) begin
            check("rst_freeze", FREEZE, 1'b0);
            check("rst_blkrd", dBlkRead, 1'b0);
            check("rst_blkwr", dBlkWrite, 1'b0);
            check("rst_addr", blk_address, 32'd0);
            check("rst_wdata", block_write_2DM, 256'd0);
            check("rst_rdata", data_read_fDM, 32'd0);
        end else if (xq.size() != 0) begin
            check("xfer_freeze", FREEZE, 1'b1);
            check("xfer_blkwr", dBlkWrite, xq[0].wr);
            check("xfer_blkrd", dBlkRead, !xq[0].wr);
            check("xfer_addr", blk_address, xq[0].addr);
            if (xq[0].wr) check("xfer_wdata", block_write_2DM, xq[0].data);
        end else if (MemRead || MemWrite) begin
            check("req_blkrd", dBlkRead, 1'b0);
            check("req_blkwr", dBlkWrite, 1'b0);
            if (m_hit(data_address_2DM)) begin
                check("hit_freeze", FREEZE, 1'b0);
                if (!MemWrite) check("hit_rdata", data_read_fDM, m_word(data_address_2DM));
            end else begin
                check("miss_freeze", FREEZE, 1'b1);
            end
        end else begin
            check("idle_freeze", FREEZE, 1'b0);
            check("idle_blk", {dBlkRead, dBlkWrite}, 2'b00);
            check("idle_rdata", data_read_fDM, m_last);
        end
    end

    // ---------------- memory responder ----------------
    int cnt_r = 0;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (!RESET || blk_ready) begin
                blk_ready = 1'b0;
                cnt_r     = 0;
            end else if (s_rd || s_wr) begin
                cnt_r++;
                if (cnt_r == DELAY) begin
                    blk_ready = 1'b1;
                    if (s_rd) block_read_fDM = mem_rd(s_addr);
                end
            end
        end
    end

    task automatic wait_done(input int max, output int frz);
        bit ok;
        ok  = 1'b0;
        frz = 0;
        for (int k = 0; k < max; k++) begin
            @(negedge CLK);
            #1;
            if (FREEZE === 1'b0) begin
                ok = 1'b1;
                break;
            end
            frz++;
        end
        check("wait_bound", ok, 1'b1);
    endtask

    task automatic request(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        @(posedge CLK);
        #1;
        MemRead          = rd;
        MemWrite         = wr;
        data_address_2DM = a;
        data_write_2DM   = d;
        rd_seen          = 1'b0;
        wb_seen          = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int frz;
        int blk0;
        logic [255:0] line;
        logic [255:0] tmp;
        tmp = mem_rd(32'h40);
        tmp[31:0]  = 32'hDEADBEEF;
        tmp[63:32] = 32'hCAFEF00D;
        mem[32'h40] = tmp;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #2 RESET = 1'b1;

        // Clean miss on 0x40
        request(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        wait_done(40, frz);
        check("miss1_freeze_cycles", frz, 5);
        check("miss1_refill_addr", rd_cap, 32'h40);
        check("miss1_rdata", data_read_fDM, 32'hDEADBEEF);

        // Read hit on the same line
        blk0 = n_blk;
        request(1'b1, 1'b0, 32'h0000_0044, 32'd0);
        wait_done(10, frz);
        check("hit44_freeze", frz, 0);
        check("hit44_rdata", data_read_fDM, 32'hCAFEF00D);

        // Store then load back, no block traffic
        request(1'b0, 1'b1, 32'h0000_0048, 32'h12345678);
        wait_done(10, frz);
        check("st48_freeze", frz, 0);
        request(1'b1, 1'b0, 32'h0000_0048, 32'd0);
        wait_done(10, frz);
        check("ld48_freeze", frz, 0);
        check("ld48_rdata", data_read_fDM, 32'h12345678);
        check("hits_no_blk", n_blk - blk0, 0);

        // Conflict miss: dirty victim written back first
        request(1'b1, 1'b0, 32'h0000_1048, 32'd0);
        wait_done(60, frz);
        check("evict_freeze_cycles", frz, 9);
        check("evict_wb_addr", wb_cap_addr, 32'h40);
        line = wb_cap_data;
        check("evict_wb_word2", line[95:64], 32'h12345678);
        check("evict_refill_addr", rd_cap, 32'h1040);
        check("evict_rdata", data_read_fDM, 32'h5A5A1048);

        // Read+write together acts as a store and dirties the line
        request(1'b1, 1'b1, 32'h0000_1044, 32'hA5A5A5A5);
        wait_done(10, frz);
        check("dual_freeze", frz, 0);
        request(1'b1, 1'b0, 32'h0000_1044, 32'd0);
        wait_done(10, frz);
        check("dual_rdata", data_read_fDM, 32'hA5A5A5A5);
        request(1'b1, 1'b0, 32'h0000_0044, 32'd0);
        wait_done(60, frz);
        check("dual_evict_freeze", frz, 9);
        check("dual_wb_addr", wb_cap_addr, 32'h1040);
        line = wb_cap_data;
        check("dual_wb_word1", line[63:32], 32'hA5A5A5A5);
        check("dual_evict_rdata", data_read_fDM, 32'hCAFEF00D);

        // Reset during refill aborts and invalidates
        request(1'b1, 1'b0, 32'h0000_1060, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        check("async_rst_freeze", FREEZE, 1'b0);
        check("async_rst_blkrd", dBlkRead, 1'b0);
        check("async_rst_addr", blk_address, 32'd0);
        check("async_rst_rdata", data_read_fDM, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        MemRead = 1'b0;
        #2 RESET = 1'b1;
        request(1'b1, 1'b0, 32'h0000_0040, 32'd0);
        wait_done(40, frz);
        check("post_rst_freeze_cycles", frz, 5);
        check("post_rst_refill_addr", rd_cap, 32'h40);
        check("post_rst_rdata", data_read_fDM, 32'hDEADBEEF);

        request(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
